trap_sequencer: RTL and testbench

Pipeline trap controller that consumes the fetch- and execute-stage exception codes produced by the exception signal logic and sequences every trap entry and return. It carries fetch-stage exceptions down a shadow pipeline so they are taken in program order at execute, flushes the pipeline, writes mepc/mcause to the CSR file, and redirects fetch to the trap or return address. It also owns the `i_reset_permission` / `i_trap_permission` region-permission bits that gate fetch from the reset-vector and trap-vector regions.

---
 rtl/trap_sequencer_if.sv | 70 +++++++
 rtl/trap_sequencer.sv | 193 +++++++++++++++++++
 tb/tb_trap_sequencer.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/trap_sequencer_if.sv
// ---------------------------------------------------------------------------
// trap_sequencer_if
//
// Purpose: bundles every signal exchanged between the pipeline and the trap
// sequencer. The pipeline side uses the master modport and the sequencer
// uses the slave modport.
//
// Parameter:
//   W                  datapath width in bits
//
// Pipeline -> sequencer:
//   i_pc_f             fetch PC (region check on reset exit)
//   i_exception_code_f fetch-stage exception code
//   i_exception_code_e execute-stage exception code
//   i_pc_e             PC of the instruction in execute
//   i_valid_e          execute holds a real instruction
//   i_advance          pipeline advances this cycle
//   i_mret_e           trap-return instruction is in execute
//
// Sequencer -> pipeline / CSR file:
//   o_flush, o_redirect_valid, o_redirect_pc, o_csr_we, o_mepc, o_mcause,
//   o_reset_permission, o_trap_permission, o_halt
// ---------------------------------------------------------------------------
`ifndef TRAP_SEQ_CODES
`define TRAP_SEQ_CODES
`define XLEN_64b                 2
`define NO_E                     4'hF
`define E_FETCH_ADDR_MISALIGNED  4'h0
`define E_FETCH_ACCESS_FAULT     4'h1
`define E_ILLEGAL_INSTR          4'h2
`define E_LOAD_ACCESS_FAULT      4'h5
`define E_ECALL                  4'hB
`define E_SP_OUT_OF_RANGE        4'hE
`endif

interface trap_sequencer_if #(
    parameter int W = 64
);
    logic [W-1:0] i_pc_f;
    logic [3:0]   i_exception_code_f;
    logic [3:0]   i_exception_code_e;
    logic [W-1:0] i_pc_e;
    logic         i_valid_e;
    logic         i_advance;
    logic         i_mret_e;

    logic         o_flush;
    logic         o_redirect_valid;
    logic [W-1:0] o_redirect_pc;
    logic         o_csr_we;
    logic [W-1:0] o_mepc;
    logic [3:0]   o_mcause;
    logic         o_reset_permission;
    logic         o_trap_permission;
    logic         o_halt;

    modport master (
        output i_pc_f, i_exception_code_f, i_exception_code_e, i_pc_e,
               i_valid_e, i_advance, i_mret_e,
        input  o_flush, o_redirect_valid, o_redirect_pc, o_csr_we, o_mepc,
               o_mcause, o_reset_permission, o_trap_permission, o_halt
    );

    modport slave (
        input  i_pc_f, i_exception_code_f, i_exception_code_e, i_pc_e,
               i_valid_e, i_advance, i_mret_e,
        output o_flush, o_redirect_valid, o_redirect_pc, o_csr_we, o_mepc,
               o_mcause, o_reset_permission, o_trap_permission, o_halt
    );
endinterface

// File: rtl/trap_sequencer.sv
// ---------------------------------------------------------------------------
// trap_sequencer
//
// Purpose: pipeline trap controller. Carries fetch-stage exception codes down
// a shadow pipeline so they are taken in program order at execute, flushes
// the pipeline on a trap, strobes mepc/mcause into the CSR file, redirects
// fetch to the trap vector and back, and owns the reset-vector and
// trap-vector fetch permission bits. A fault while already handling a trap
// (or before leaving the reset region) halts the core until reset.
//
// Ports:
//   i_clk    clock, rising edge
//   i_rst_n  asynchronous active-low reset
//   bus      trap_sequencer_if.slave (pipeline inputs, control outputs)
// ---------------------------------------------------------------------------
`ifndef TRAP_SEQ_CODES
`define TRAP_SEQ_CODES
`define XLEN_64b                 2
`define NO_E                     4'hF
`define E_FETCH_ADDR_MISALIGNED  4'h0
`define E_FETCH_ACCESS_FAULT     4'h1
`define E_ILLEGAL_INSTR          4'h2
`define E_LOAD_ACCESS_FAULT      4'h5
`define E_ECALL                  4'hB
`define E_SP_OUT_OF_RANGE        4'hE
`endif

module trap_sequencer #(
    parameter int           XLEN      = `XLEN_64b,
    parameter int           W         = 1 << (XLEN + 4),
    // Trap vector entry; lives in region pc[20:18] = 3'b000
    parameter logic [W-1:0] TVEC_BASE = '0
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    trap_sequencer_if.slave bus
);

    typedef enum logic [2:0] {
        RESET_RUN,
        NORMAL,
        TRAP_SAVE,
        TRAP_REDIRECT,
        TRAP_RUN,
        RETURN,
        HALT
    } state_t;

    state_t       state;
    state_t       state_next;
    logic [3:0]   code_d;
    logic [3:0]   code_x;
    logic [3:0]   exc;
    logic [W-1:0] mepc_q;
    logic [3:0]   mcause_q;
    logic         trap_perm_q;
    logic         flush;
    logic         capture;
    logic         redirect_valid;
    logic [W-1:0] redirect_pc;
    logic         csr_we;
    logic         reset_perm;
    logic         halt;
    logic         unused_pc_bits;

    // Only the region field of the fetch PC matters here.
    assign unused_pc_bits = ^{bus.i_pc_f[W-1:21], bus.i_pc_f[17:0]};

    // A fetch fault is older than anything the execute stage raised for the
    // same instruction, so the shadow code wins. Bubbles never trap.
    assign exc = bus.i_valid_e
               ? ((code_x != `NO_E) ? code_x : bus.i_exception_code_e)
               : `NO_E;

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= RESET_RUN;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and output decode. The entry states do not look at
    // i_advance so the trap entry sequence always takes a fixed number
    // of cycles.
    always_comb begin
        state_next     = state;
        flush          = 1'b0;
        capture        = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        csr_we         = 1'b0;
        reset_perm     = 1'b0;
        halt           = 1'b0;
        case (state)
            RESET_RUN: begin
                reset_perm = 1'b1;
                if (exc != `NO_E) begin
                    state_next = HALT;
                end else if (bus.i_pc_f[20:18] == 3'b010) begin
                    state_next = NORMAL;
                end
            end
            NORMAL: begin
                if (exc != `NO_E) begin
                    flush      = 1'b1;
                    capture    = 1'b1;
                    state_next = TRAP_SAVE;
                end
            end
            TRAP_SAVE: begin
                csr_we     = 1'b1;
                state_next = TRAP_REDIRECT;
            end
            TRAP_REDIRECT: begin
                redirect_valid = 1'b1;
                redirect_pc    = TVEC_BASE;
                state_next     = TRAP_RUN;
            end
            TRAP_RUN: begin
                if (exc != `NO_E) begin
                    state_next = HALT;
                end else if (bus.i_mret_e && bus.i_valid_e) begin
                    flush      = 1'b1;
                    state_next = RETURN;
                end
            end
            RETURN: begin
                redirect_valid = 1'b1;
                redirect_pc    = mepc_q + W'(4);
                state_next     = NORMAL;
            end
            HALT: begin
                halt  = 1'b1;
                flush = 1'b1;
            end
            default: begin
                state_next = HALT;
            end
        endcase
    end

    // Shadow pipeline for fetch exception codes. A flush discards whatever
    // would otherwise have been shifted in on the same edge.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            code_d <= `NO_E;
            code_x <= `NO_E;
        end else if (flush) begin
            code_d <= `NO_E;
            code_x <= `NO_E;
        end else if (bus.i_advance) begin
            code_d <= bus.i_exception_code_f;
            code_x <= code_d;
        end
    end

    // Trap record; held until the next trap is taken.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            mepc_q   <= '0;
            mcause_q <= `NO_E;
        end else if (capture) begin
            mepc_q   <= bus.i_pc_e;
            mcause_q <= exc;
        end
    end

    // Trap-region permission: opens as fetch is sent to the vector and
    // closes as fetch is sent back, so it is high exactly while fetching
    // handler code.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            trap_perm_q <= 1'b0;
        end else if (state == TRAP_REDIRECT) begin
            trap_perm_q <= 1'b1;
        end else if (state == RETURN) begin
            trap_perm_q <= 1'b0;
        end
    end

    assign bus.o_flush            = flush;
    assign bus.o_redirect_valid   = redirect_valid;
    assign bus.o_redirect_pc      = redirect_pc;
    assign bus.o_csr_we           = csr_we;
    assign bus.o_mepc             = mepc_q;
    assign bus.o_mcause           = mcause_q;
    assign bus.o_reset_permission = reset_perm;
    assign bus.o_trap_permission  = trap_perm_q;
    assign bus.o_halt             = halt;

endmodule

// File: tb/tb_trap_sequencer.sv
// ---------------------------------------------------------------------------
// tb_trap_sequencer
//
// Purpose: directed self-checking bench for trap_sequencer. Expected CSR
// writes and redirects are queued when the causing stimulus is driven and
// compared when the DUT strobes them; cycle-exact timing is checked directly.
// ---------------------------------------------------------------------------
`ifndef TRAP_SEQ_CODES
`define TRAP_SEQ_CODES
`define XLEN_64b                 2
`define NO_E                     4'hF
`define E_FETCH_ADDR_MISALIGNED  4'h0
`define E_FETCH_ACCESS_FAULT     4'h1
`define E_ILLEGAL_INSTR          4'h2
`define E_LOAD_ACCESS_FAULT      4'h5
`define E_ECALL                  4'hB
`define E_SP_OUT_OF_RANGE        4'hE
`endif

module tb_trap_sequencer;

    localparam logic [63:0] TVEC = 64'h0;

    typedef struct {
        logic [63:0] mepc;
        logic [3:0]  mcause;
    } csr_exp_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    csr_exp_t    exp_csr[$];
    logic [63:0] exp_redir[$];

    trap_sequencer_if #(.W(64)) bus ();

    trap_sequencer #(
        .XLEN      (`XLEN_64b),
        .TVEC_BASE (TVEC)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus.slave)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single comparison point; every check in the bench goes through here.
    task automatic checkOutput(input string tag, input logic [63:0] obs,
                               input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [63:0] pc_f, input logic [63:0] pc_e,
                                 input logic [3:0] code_f, input logic [3:0] code_e,
                                 input logic valid, input logic adv, input logic mret);
        bus.i_pc_f             = pc_f;
        bus.i_pc_e             = pc_e;
        bus.i_exception_code_f = code_f;
        bus.i_exception_code_e = code_e;
        bus.i_valid_e          = valid;
        bus.i_advance          = adv;
        bus.i_mret_e           = mret;
    endtask

    // Scoreboard side: pop and compare whenever the DUT strobes a CSR write
    // or a redirect; a strobe with nothing queued is itself an error.
    task automatic observeEvents();
        csr_exp_t    e;
        logic [63:0] r;
        if (bus.o_csr_we === 1'b1) begin
            if (exp_csr.size() == 0) begin
                checkOutput("csr_we_unexpected", 64'(bus.o_csr_we), 64'd0);
            end else begin
                e = exp_csr.pop_front();
                checkOutput("mepc", bus.o_mepc, e.mepc);
                checkOutput("mcause", 64'(bus.o_mcause), 64'(e.mcause));
            end
        end
        if (bus.o_redirect_valid === 1'b1) begin
            if (exp_redir.size() == 0) begin
                checkOutput("redirect_unexpected", 64'(bus.o_redirect_valid), 64'd0);
            end else begin
                r = exp_redir.pop_front();
                checkOutput("redirect_pc", bus.o_redirect_pc, r);
            end
        end
    endtask

    task automatic sample();
        @(negedge clk);
        observeEvents();
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    // The two fixed entry cycles (stalled, to show they ignore i_advance)
    // followed by the first handler cycle.
    task automatic runEntry();
        nextCycle();
        applyStimulus(64'h80014, 64'h0, `NO_E, `NO_E, 1'b0, 1'b0, 1'b0);
        sample();
        checkOutput("entry_csr_we", 64'(bus.o_csr_we), 64'd1);
        checkOutput("entry_no_redirect_yet", 64'(bus.o_redirect_valid), 64'd0);
        nextCycle();
        sample();
        checkOutput("entry_redirect", 64'(bus.o_redirect_valid), 64'd1);
        checkOutput("entry_perm_before", 64'(bus.o_trap_permission), 64'd0);
        nextCycle();
        applyStimulus(TVEC, 64'h0, `NO_E, `NO_E, 1'b1, 1'b1, 1'b0);
        sample();
        checkOutput("trap_perm_on", 64'(bus.o_trap_permission), 64'd1);
        checkOutput("trap_run_no_flush", 64'(bus.o_flush), 64'd0);
    endtask

    task automatic runReturn(input logic [63:0] ret_pc);
        nextCycle();
        applyStimulus(64'h8, 64'h4, `NO_E, `NO_E, 1'b1, 1'b1, 1'b1);
        exp_redir.push_back(ret_pc);
        sample();
        checkOutput("mret_flush", 64'(bus.o_flush), 64'd1);
        nextCycle();
        applyStimulus(64'hC, 64'h0, `NO_E, `NO_E, 1'b0, 1'b1, 1'b0);
        sample();
        checkOutput("ret_redirect", 64'(bus.o_redirect_valid), 64'd1);
        checkOutput("perm_during_ret", 64'(bus.o_trap_permission), 64'd1);
        nextCycle();
        applyStimulus(ret_pc, 64'h0, `NO_E, `NO_E, 1'b0, 1'b1, 1'b0);
        sample();
        checkOutput("perm_off", 64'(bus.o_trap_permission), 64'd0);
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_reset_perm"}, 64'(bus.o_reset_permission), 64'd1);
        checkOutput({tag, "_flush"}, 64'(bus.o_flush), 64'd0);
        checkOutput({tag, "_redirect"}, 64'(bus.o_redirect_valid), 64'd0);
        checkOutput({tag, "_redirect_pc"}, bus.o_redirect_pc, 64'd0);
        checkOutput({tag, "_csr_we"}, 64'(bus.o_csr_we), 64'd0);
        checkOutput({tag, "_mepc"}, bus.o_mepc, 64'd0);
        checkOutput({tag, "_mcause"}, 64'(bus.o_mcause), 64'(`NO_E));
        checkOutput({tag, "_trap_perm"}, 64'(bus.o_trap_permission), 64'd0);
        checkOutput({tag, "_halt"}, 64'(bus.o_halt), 64'd0);
    endtask

    // Release reset away from the rising edge and realign to the cycle grid.
    task automatic releaseReset();
        @(negedge clk);
        rst_n = 1'b1;
        nextCycle();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        applyStimulus(64'h0, 64'h0, `NO_E, `NO_E, 1'b0, 1'b1, 1'b0);
        #12;
        checkResetValues("por");
        releaseReset();

        // Reset exit: permission drops the cycle after fetch enters 0x80000
        $display("[TB] reset exit");
        applyStimulus(64'h40008, 64'h0, `NO_E, `NO_E, 1'b0, 1'b1, 1'b0);
        sample();
        checkOutput("reset_perm_40008", 64'(bus.o_reset_permission), 64'd1);
        nextCycle();
        applyStimulus(64'h80000, 64'h0, `NO_E, `NO_E, 1'b0, 1'b1, 1'b0);
        sample();
        checkOutput("reset_perm_80000", 64'(bus.o_reset_permission), 64'd1);
        nextCycle();
        applyStimulus(64'h80004, 64'h0, `NO_E, `NO_E, 1'b0, 1'b1, 1'b0);
        sample();
        checkOutput("reset_perm_dropped", 64'(bus.o_reset_permission), 64'd0);

        // Illegal fetch at 0x80010 reaches E two cycles later
        $display("[TB] illegal fetch");
        nextCycle();
        applyStimulus(64'h80010, 64'h80008, `E_ILLEGAL_INSTR, `NO_E, 1'b1, 1'b1, 1'b0);
        sample();
        checkOutput("ill_no_flush_f", 64'(bus.o_flush), 64'd0);
        nextCycle();
        applyStimulus(64'h80014, 64'h8000C, `NO_E, `NO_E, 1'b1, 1'b1, 1'b0);
        sample();
        checkOutput("ill_no_flush_d", 64'(bus.o_flush), 64'd0);
        nextCycle();
        // Code presented alongside the flush must be discarded
        applyStimulus(64'h80018, 64'h80010, `E_ILLEGAL_INSTR, `NO_E, 1'b1, 1'b1, 1'b0);
        exp_csr.push_back('{mepc: 64'h80010, mcause: `E_ILLEGAL_INSTR});
        exp_redir.push_back(TVEC);
        sample();
        checkOutput("ill_flush", 64'(bus.o_flush), 64'd1);
        runEntry();
        for (int i = 0; i < 3; i++) begin
            nextCycle();
            applyStimulus(64'h4, 64'h0, `NO_E, `NO_E, 1'b1, 1'b1, 1'b0);
            sample();
            checkOutput("discarded_code_no_halt", 64'(bus.o_halt), 64'd0);
        end
        runReturn(64'h80014);

        // Fetch-stage code wins over execute-stage code
        $display("[TB] fetch vs execute priority");
        nextCycle();
        applyStimulus(64'h80030, 64'h80028, `E_FETCH_ADDR_MISALIGNED, `NO_E, 1'b1, 1'b1, 1'b0);
        sample();
        nextCycle();
        applyStimulus(64'h80034, 64'h8002C, `NO_E, `NO_E, 1'b1, 1'b1, 1'b0);
        sample();
        nextCycle();
        applyStimulus(64'h80038, 64'h80030, `NO_E, `E_LOAD_ACCESS_FAULT, 1'b1, 1'b1, 1'b0);
        exp_csr.push_back('{mepc: 64'h80030, mcause: `E_FETCH_ADDR_MISALIGNED});
        exp_redir.push_back(TVEC);
        sample();
        checkOutput("prio_flush", 64'(bus.o_flush), 64'd1);
        runEntry();
        runReturn(64'h80034);

        // ECALL held in a stalled bubble, then round trip
        $display("[TB] stall and ecall round trip");
        for (int i = 0; i < 2; i++) begin
            nextCycle();
            applyStimulus(64'h80024, 64'h80020, `NO_E, `E_ECALL, 1'b0, 1'b0, 1'b0);
            sample();
            checkOutput("stall_no_trap", 64'(bus.o_flush), 64'd0);
        end
        nextCycle();
        applyStimulus(64'h80024, 64'h80020, `NO_E, `E_ECALL, 1'b1, 1'b0, 1'b0);
        exp_csr.push_back('{mepc: 64'h80020, mcause: `E_ECALL});
        exp_redir.push_back(TVEC);
        sample();
        checkOutput("ecall_flush", 64'(bus.o_flush), 64'd1);
        runEntry();
        runReturn(64'h80024);

        // Double fault: exception plus mret in TRAP_RUN halts, no redirect
        $display("[TB] double fault");
        nextCycle();
        applyStimulus(64'h80044, 64'h80040, `NO_E, `E_ILLEGAL_INSTR, 1'b1, 1'b1, 1'b0);
        exp_csr.push_back('{mepc: 64'h80040, mcause: `E_ILLEGAL_INSTR});
        exp_redir.push_back(TVEC);
        sample();
        runEntry();
        nextCycle();
        applyStimulus(64'h4, 64'h4, `NO_E, `E_SP_OUT_OF_RANGE, 1'b1, 1'b1, 1'b1);
        sample();
        checkOutput("dfault_no_redirect", 64'(bus.o_redirect_valid), 64'd0);
        for (int i = 0; i < 3; i++) begin
            nextCycle();
            applyStimulus(64'h8, 64'h0, `NO_E, `NO_E, 1'b0, 1'b1, 1'b0);
            sample();
            checkOutput("halt_held", 64'(bus.o_halt), 64'd1);
            checkOutput("halt_flush", 64'(bus.o_flush), 64'd1);
        end
        rst_n = 1'b0;
        #1;
        checkResetValues("halt_rst");
        releaseReset();

        // Exception while still in the reset region halts
        $display("[TB] exception in reset region");
        applyStimulus(64'h40000, 64'h40000, `NO_E, `E_ILLEGAL_INSTR, 1'b1, 1'b1, 1'b0);
        sample();
        checkOutput("rr_not_halted_yet", 64'(bus.o_halt), 64'd0);
        nextCycle();
        applyStimulus(64'h40004, 64'h0, `NO_E, `NO_E, 1'b0, 1'b1, 1'b0);
        sample();
        checkOutput("rr_halt", 64'(bus.o_halt), 64'd1);
        checkOutput("rr_perm_gone", 64'(bus.o_reset_permission), 64'd0);
        rst_n = 1'b0;
        #1;
        releaseReset();

        // Reset asserted during TRAP_REDIRECT acts without a clock edge
        $display("[TB] reset mid-trap");
        applyStimulus(64'h80000, 64'h0, `NO_E, `NO_E, 1'b0, 1'b1, 1'b0);
        sample();
        nextCycle();
        applyStimulus(64'h80054, 64'h80050, `NO_E, `E_ILLEGAL_INSTR, 1'b1, 1'b1, 1'b0);
        exp_csr.push_back('{mepc: 64'h80050, mcause: `E_ILLEGAL_INSTR});
        exp_redir.push_back(TVEC);
        sample();
        checkOutput("mid_flush", 64'(bus.o_flush), 64'd1);
        nextCycle();
        applyStimulus(64'h80058, 64'h0, `NO_E, `NO_E, 1'b0, 1'b0, 1'b0);
        sample();
        nextCycle();
        sample();
        checkOutput("mid_in_redirect", 64'(bus.o_redirect_valid), 64'd1);
        #1;
        rst_n = 1'b0;
        #1;
        checkResetValues("mid_rst");
        releaseReset();

        checkOutput("csr_queue_drained", 64'(exp_csr.size()), 64'd0);
        checkOutput("redir_queue_drained", 64'(exp_redir.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
